// File: rtl/rl_ram_1r1w_arb.sv
// Two-client arbiter in front of a 1R1W RAM: independent write and read arbitration
// with optional grant locking, plus read-response tracking for the shared read-data bus.
module rl_ram_1r1w_arb #(
  parameter int    ABITS  = 10,
  parameter int    DBITS  = 32,
  parameter string ARB    = "RR",
  localparam int   BEBITS = (DBITS + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            wreq_i,
  input  logic [1:0]            wlock_i,
  input  logic [2*ABITS-1:0]    waddr_i,
  input  logic [2*DBITS-1:0]    wdata_i,
  input  logic [2*BEBITS-1:0]   wbe_i,
  output logic [1:0]            wgnt_o,
  input  logic [1:0]            rreq_i,
  input  logic [1:0]            rlock_i,
  input  logic [2*ABITS-1:0]    raddr_i,
  output logic [1:0]            rgnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DBITS-1:0]      rdata_o,
  output logic [ABITS-1:0]      mem_waddr_o,
  output logic [DBITS-1:0]      mem_din_o,
  output logic [BEBITS-1:0]     mem_be_o,
  output logic                  mem_we_o,
  output logic [ABITS-1:0]      mem_raddr_o,
  output logic                  mem_re_o,
  input  logic [DBITS-1:0]      mem_dout_i
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

  localparam bit ARB_FIXED = (ARB == "FIXED");

  // Side 0 is the write port, side 1 the read port; both run the same arbiter.
  logic [1:0][1:0] req_s;
  logic [1:0][1:0] lock_s;
  logic [1:0][1:0] gnt_s;
  logic [1:0]      rvalid_reg;

  assign req_s  = {rreq_i, wreq_i};
  assign lock_s = {rlock_i, wlock_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      lock_state_e state_reg;
      logic        prio_reg;
      logic [1:0]  gnt;

      always_comb begin
        gnt = 2'b00;
        unique case (state_reg)
          UNLOCKED: begin
            if (req_s[gi] == 2'b11)
              gnt = (ARB_FIXED || !prio_reg) ? 2'b01 : 2'b10;
            else
              gnt = req_s[gi];
          end
          LOCKED0: gnt = {1'b0, req_s[gi][0]};
          LOCKED1: gnt = {req_s[gi][1], 1'b0};
          default: gnt = 2'b00;
        endcase
        if (!rst_ni)
          gnt = 2'b00;
      end

      assign gnt_s[gi] = gnt;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          state_reg <= UNLOCKED;
          prio_reg  <= 1'b0;
        end else begin
          unique case (state_reg)
            UNLOCKED: begin
              if (gnt[0] && lock_s[gi][0])
                state_reg <= LOCKED0;
              else if (gnt[1] && lock_s[gi][1])
                state_reg <= LOCKED1;
              // Pointer moves to the loser of this grant.
              if (!ARB_FIXED && (gnt != 2'b00))
                prio_reg <= gnt[0];
            end
            LOCKED0: if (!lock_s[gi][0]) state_reg <= UNLOCKED;
            LOCKED1: if (!lock_s[gi][1]) state_reg <= UNLOCKED;
            default: state_reg <= UNLOCKED;
          endcase
        end
      end
    end
  endgenerate

  assign wgnt_o   = gnt_s[0];
  assign rgnt_o   = gnt_s[1];
  assign mem_we_o = |gnt_s[0];
  assign mem_re_o = |gnt_s[1];

  always_comb begin
    mem_waddr_o = '0;
    mem_din_o   = '0;
    mem_be_o    = '0;
    mem_raddr_o = '0;
    for (int k = 0; k < 2; k++) begin
      if (gnt_s[0][k]) begin
        mem_waddr_o = waddr_i[k*ABITS +: ABITS];
        mem_din_o   = wdata_i[k*DBITS +: DBITS];
        mem_be_o    = wbe_i[k*BEBITS +: BEBITS];
      end
      if (gnt_s[1][k])
        mem_raddr_o = raddr_i[k*ABITS +: ABITS];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      rvalid_reg <= 2'b00;
    else
      rvalid_reg <= gnt_s[1];
  end

  // A response still in flight when reset arrives is dropped, not delivered.
  assign rvalid_o = rst_ni ? rvalid_reg : 2'b00;
  assign rdata_o  = (|rvalid_o) ? mem_dout_i : '0;

endmodule
